// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: control strobes, bus and ALU inputs into the sequencer,
// plus the registered instruction, step and flag state that feeds the decoder.
interface instruction_sequencer_if #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int INSTRUCTION_STEPS = 32
);
    localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS);
    logic                         i_step_en;
    logic                         i_resume;
    logic [INSTRUCTION_WIDTH-1:0] i_bus;
    logic                         i_ii;
    logic                         i_adv;
    logic                         i_hlt;
    logic                         i_el;
    logic                         i_alu_zero;
    logic                         i_alu_carry;
    logic                         i_alu_odd;
    logic [INSTRUCTION_WIDTH-1:0] o_instruction;
    logic [STEP_WIDTH-1:0]        o_step;
    logic                         o_zero;
    logic                         o_carry;
    logic                         o_odd;
    logic                         o_halted;
    logic                         o_step_overflow;
    modport master (
        output i_step_en, i_resume, i_bus, i_ii, i_adv, i_hlt, i_el, i_alu_zero, i_alu_carry, i_alu_odd,
        input  o_instruction, o_step, o_zero, o_carry, o_odd, o_halted, o_step_overflow
    );
    modport slave (
        input  i_step_en, i_resume, i_bus, i_ii, i_adv, i_hlt, i_el, i_alu_zero, i_alu_carry, i_alu_odd,
        output o_instruction, o_step, o_zero, o_carry, o_odd, o_halted, o_step_overflow
    );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: instruction register, micro-step counter and ALU flag latch
// driving the decoder; advances, restarts, halts and latches on decoder strobes.
module instruction_sequencer #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int INSTRUCTION_STEPS = 32
) (
    input logic                    i_clk,
    input logic                    i_reset,
    instruction_sequencer_if.slave sif
);
    localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS);
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [STEP_WIDTH-1:0]        step_q, step_d;
    logic [2:0]                   flags_q, flags_d;
    logic                         halted_q, halted_d;
    logic                         ovf_q, ovf_d;
    logic                         active, wrap;
    always_comb begin
        active   = sif.i_step_en & ~halted_q;
        wrap     = active & ~sif.i_hlt & ~sif.i_adv & (step_q == LAST_STEP);
        instr_d  = (active & sif.i_ii) ? sif.i_bus : instr_q;
        flags_d  = (active & sif.i_el) ? {sif.i_alu_zero, sif.i_alu_carry, sif.i_alu_odd} : flags_q;
        halted_d = halted_q ? ~sif.i_resume : (active & sif.i_hlt);
        ovf_d    = ovf_q | wrap;
        // resume restarts the instruction at step 0 even without step enable
        step_d   = halted_q ? (sif.i_resume ? '0 : step_q) :
                   (!active || sif.i_hlt) ? step_q :
                   (sif.i_adv || wrap) ? '0 : step_q + STEP_WIDTH'(1);
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            instr_q  <= '0;
            step_q   <= '0;
            flags_q  <= '0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            step_q   <= step_d;
            flags_q  <= flags_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
        end
    end
    assign sif.o_instruction   = instr_q;
    assign sif.o_step          = step_q;
    assign {sif.o_zero, sif.o_carry, sif.o_odd} = flags_q;
    assign sif.o_halted        = halted_q;
    assign sif.o_step_overflow = ovf_q;
endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Sequential counterpart to the instruction decoder. It holds the instruction register, the micro-step counter and the ALU flag register. These registered values feed the decoder's instruction, step and zero/carry/odd inputs. It consumes the decoder's II, ADV, HLT and EL control strobes to advance, restart, halt and latch state. It sits between the bus/ALU and the decoder in the CPU core.

Parameters:
INSTRUCTION_WIDTH, 16, width of instruction register and bus input
INSTRUCTION_STEPS, 32, number of micro-steps per instruction; STEP_WIDTH = $clog2(INSTRUCTION_STEPS) (localparam)

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_step_en  input  1  clock enable for sequencing (manual single-step when pulsed)
i_resume  input  1  clears halt state
i_bus  input  INSTRUCTION_WIDTH  bus value loaded into instruction register
i_ii  input  1  instruction-register load strobe (control word II)
i_adv  input  1  advance to next instruction (control word ADV)
i_hlt  input  1  halt strobe (control word HLT)
i_el  input  1  flag-latch strobe (control word EL)
i_alu_zero  input  1  ALU zero result
i_alu_carry  input  1  ALU carry result
i_alu_odd  input  1  ALU odd result
o_instruction  output  INSTRUCTION_WIDTH  instruction register, to decoder
o_step  output  STEP_WIDTH  current micro-step, to decoder
o_zero  output  1  latched zero flag
o_carry  output  1  latched carry flag
o_odd  output  1  latched odd flag
o_halted  output  1  core halted
o_step_overflow  output  1  sticky error: step counter wrapped without ADV

Behaviour:
- Reset (async, i_reset=1): o_instruction=0 (NOP), o_step=0, o_zero/o_carry/o_odd=0, o_halted=0, o_step_overflow=0. Reset asserted mid-instruction aborts immediately. On release, fetch restarts at step 0.
- All outputs are registered. The decoder sees updated values in the cycle after the strobe edge. No combinational path exists from inputs to outputs.
- Active cycle: i_step_en=1 and o_halted=0. In inactive cycles, i_ii, i_adv, i_hlt and i_el are ignored and all state holds. The one exception is i_resume below.
- Step counter, evaluated on each active cycle in priority order:
  1. i_hlt=1: o_halted<=1. o_step holds, even if i_adv is also 1.
  2. i_adv=1: o_step<=0.
  3. o_step==INSTRUCTION_STEPS-1: o_step<=0 and o_step_overflow<=1.
  4. Otherwise: o_step<=o_step+1.
- o_step_overflow is sticky until reset and does not stop sequencing.
- Instruction register: on an active cycle with i_ii=1, o_instruction<=i_bus. This is independent of the step logic. II with ADV or HLT in the same cycle applies both.
- Flags: on an active cycle with i_el=1, o_zero/o_carry/o_odd <= i_alu_zero/i_alu_carry/i_alu_odd. Otherwise the flags hold, including across instructions and halt.
- Halt state: while o_halted=1, nothing changes except on i_resume=1. i_resume then sets o_halted<=0 and o_step<=0, regardless of i_step_en. o_instruction and the flags are retained. i_resume while not halted has no effect.
- i_hlt and i_resume in the same cycle while not halted: the halt is taken and resume is ignored.
- Step width arithmetic is unsigned modulo 2^STEP_WIDTH. INSTRUCTION_STEPS must be a power of two ≥ 4.

Test Plan:
- Reset: assert i_reset with arbitrary inputs toggling -> all outputs 0. Assert i_reset at step 2 mid-instruction -> o_step=0 asynchronously, before the next clock edge.
- Fetch/LD sequence: i_step_en=1. Pulse i_ii with i_bus=16'h0001 at step 1, then i_adv at step 3 -> o_step sequence 0,1,2,3,0; o_instruction=16'h0001 from the cycle after step 1.
- Halt/resume: i_hlt at step 2 -> o_halted=1, o_step stays 2. i_adv, i_ii and i_el pulses change nothing. Pulse i_resume -> o_halted=0, o_step=0 next cycle.
- Flags: i_el=1 with zero=1, carry=0, odd=1 -> o_zero=1, o_carry=0, o_odd=1. Change ALU inputs with i_el=0 for 10 cycles -> flags unchanged.
- Step enable: hold i_step_en=0 for 5 cycles at step 1 with i_adv=1 -> o_step stays 1. Raise i_step_en -> o_step=0.
- Overflow: run 32 active cycles with no i_adv -> o_step wraps 31->0, o_step_overflow=1. It stays 1 after later ADV and clears only on reset.
